// File: rtl/axi_wresp_pkg.sv
// Shared types and helpers for the AXI write-response router and its arbiter.
package axi_wresp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } onehot_t;

  // valid is set only when exactly one bit of v is high
  function automatic onehot_t onehot_to_idx(input logic [31:0] v);
    onehot_t r;
    int      cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        cnt   = cnt + 1;
        r.idx = 5'(i);
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/axi_wresp_rr_router_if.sv
// B-channel bundle between NUM_S slaves and NUM_M masters around the response router.
// Handshake: a beat transfers on a clock edge where VALID and READY are both high;
// once VALID is raised toward a master, it and its payload stay put until READY.
interface axi_wresp_rr_router_if #(
  parameter int NUM_S = 3,
  parameter int NUM_M = 2,
  parameter int ID_W  = 4,
  parameter int IDS_W = 8
);
  logic [NUM_S*IDS_W-1:0] BID_S;
  logic [NUM_S*2-1:0]     BRESP_S;
  logic [NUM_S-1:0]       BVALID_S;
  logic [NUM_S-1:0]       BREADY_S;
  logic [NUM_M*ID_W-1:0]  BID_M;
  logic [NUM_M*2-1:0]     BRESP_M;
  logic [NUM_M-1:0]       BVALID_M;
  logic [NUM_M-1:0]       BREADY_M;

  // router side
  modport master (
    input  BID_S, BRESP_S, BVALID_S, BREADY_M,
    output BREADY_S, BID_M, BRESP_M, BVALID_M
  );

  // environment side (slaves driving in, masters consuming)
  modport slave (
    output BID_S, BRESP_S, BVALID_S, BREADY_M,
    input  BREADY_S, BID_M, BRESP_M, BVALID_M
  );
endinterface

// File: rtl/axi_wresp_rr_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after its pointer;
// the pointer moves past the winner only when the grant is taken (advance).
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    any     = |req;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_wresp_rr_router.sv
// Routes B responses from NUM_S slaves to NUM_M masters through a one-entry slot.
// Optional WRESP_DROP_CNT_EN adds an 8-bit saturating count of unroutable responses.
module axi_wresp_rr_router
  import axi_wresp_pkg::*;
#(
  parameter int NUM_S = 3,
  parameter int NUM_M = 2,
  parameter int ID_W  = 4,
  parameter int IDS_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_wresp_rr_router_if.master  bus,
  output state_t                 fsm_state
`ifdef WRESP_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int MSEL_W = IDS_W - ID_W;
  localparam int DST_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int IDX_W  = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    slot_id;
  logic [1:0]         slot_resp;
  logic [DST_W-1:0]   slot_dst;

  logic [NUM_S-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any;
  logic               advance;
  logic               master_done;
  logic               routable;
  logic               load;
  logic [IDS_W-1:0]   sel_id;
  logic [1:0]         sel_resp;
  onehot_t            oh;

  rr_arbiter #(.N(NUM_S)) u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (bus.BVALID_S),
    .advance (advance),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    sel_id   = '0;
    sel_resp = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (gnt[s]) begin
        sel_id   = bus.BID_S[s*IDS_W +: IDS_W];
        sel_resp = bus.BRESP_S[s*2 +: 2];
      end
    end
    oh       = onehot_to_idx(32'(sel_id[IDS_W-1:ID_W]));
    routable = oh.valid && (int'(oh.idx) < NUM_M);
  end

  // A slave is only accepted when the slot is free or emptying this cycle.
  // Gating with rst keeps BREADY_S low for the whole reset window.
  assign master_done  = (state_q == HOLD) && bus.BREADY_M[slot_dst];
  assign advance      = rst && any && ((state_q == IDLE) || master_done);
  assign load         = advance && routable;
  assign bus.BREADY_S = advance ? gnt : '0;
  assign fsm_state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = HOLD;
      HOLD:    if (master_done) state_d = load ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      slot_id   <= '0;
      slot_resp <= '0;
      slot_dst  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        slot_id   <= sel_id[ID_W-1:0];
        slot_resp <= sel_resp;
        slot_dst  <= oh.idx[DST_W-1:0];
      end
    end
  end

  always_comb begin
    bus.BVALID_M = '0;
    bus.BID_M    = '0;
    bus.BRESP_M  = '0;
    if (state_q == HOLD) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (slot_dst == DST_W'(m)) begin
          bus.BVALID_M[m]           = 1'b1;
          bus.BID_M[m*ID_W +: ID_W] = slot_id;
          bus.BRESP_M[m*2 +: 2]     = slot_resp;
        end
      end
    end
  end

`ifdef WRESP_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (advance && !routable && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  // MSEL_W documents the master-select field width carved from the slave ID.
  localparam int MSEL_W_CHECK = MSEL_W;

endmodule

// File: tb/tb_axi_wresp_rr_router.sv
// Directed plus randomized bench for axi_wresp_rr_router against a cycle-level reference model.
module tb_axi_wresp_rr_router;
  import axi_wresp_pkg::*;

  localparam int NS   = 3;
  localparam int NM   = 2;
  localparam int IW   = 4;
  localparam int IDSW = 8;
  localparam int SB_W = 7;

  logic   clk;
  logic   rst;
  state_t fsm_state;
`ifdef WRESP_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  axi_wresp_rr_router_if #(.NUM_S(NS), .NUM_M(NM), .ID_W(IW), .IDS_W(IDSW)) bif ();

  axi_wresp_rr_router #(.NUM_S(NS), .NUM_M(NM), .ID_W(IW), .IDS_W(IDSW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .fsm_state (fsm_state)
`ifdef WRESP_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // reference model state
  int              m_ptr;
  bit              m_full;
  int              m_dst;
  logic [IW-1:0]   m_id;
  logic [1:0]      m_resp;
  int              m_drops;
  logic [SB_W-1:0] exp_q[$];
  logic [NS-1:0]   last_rs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_reset();
    m_ptr   = 0;
    m_full  = 0;
    m_dst   = 0;
    m_id    = '0;
    m_resp  = '0;
    m_drops = 0;
    exp_q.delete();
  endfunction

  // driver + checker for one clock cycle
  task automatic step(input logic [NS-1:0] v, input logic [NS*IDSW-1:0] ids,
                      input logic [NS*2-1:0] rs, input logic [NM-1:0] rdy);
    int              g;
    bit              found, done, ok;
    logic [NS-1:0]   exp_rs;
    logic [NM-1:0]   exp_vm;
    logic [NM*IW-1:0] exp_bid;
    logic [NM*2-1:0] exp_br;
    logic [IDSW-1:0] b;
    logic [3:0]      f;
    int              obs_dst;
    logic [SB_W-1:0] obs, expv;

    @(negedge clk);
    bif.BVALID_S = v;
    bif.BID_S    = ids;
    bif.BRESP_S  = rs;
    bif.BREADY_M = rdy;
    #1;
    exp_vm  = '0;
    exp_bid = '0;
    exp_br  = '0;
    if (m_full) begin
      exp_vm[m_dst]             = 1'b1;
      exp_bid[m_dst*IW +: IW]   = m_id;
      exp_br[m_dst*2 +: 2]      = m_resp;
    end
    done  = m_full && rdy[m_dst];
    ok    = !m_full || done;
    found = 0;
    g     = 0;
    for (int k = 0; k < NS; k++) begin
      if (!found && v[(m_ptr + k) % NS]) begin
        found = 1;
        g     = (m_ptr + k) % NS;
      end
    end
    exp_rs = '0;
    if (ok && found) exp_rs[g] = 1'b1;

    chk("bready_s", 32'(bif.BREADY_S), 32'(exp_rs));
    chk("bvalid_m", 32'(bif.BVALID_M), 32'(exp_vm));
    chk("bid_m",    32'(bif.BID_M),    32'(exp_bid));
    chk("bresp_m",  32'(bif.BRESP_M),  32'(exp_br));
    chk("state",    32'(fsm_state),    m_full ? 32'(HOLD) : 32'(IDLE));
`ifdef WRESP_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(sat255(m_drops)));
`endif
    last_rs = bif.BREADY_S;

    // scoreboard: what leaves on a master handshake must be the oldest routed response
    if (done) begin
      obs_dst = 0;
      for (int m = 0; m < NM; m++) if (bif.BVALID_M[m]) obs_dst = m;
      obs  = {1'(obs_dst), bif.BID_M[obs_dst*IW +: IW], bif.BRESP_M[obs_dst*2 +: 2]};
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("sb_delivery", 32'(obs), 32'(expv));
    end

    @(posedge clk);
    if (done) m_full = 0;
    if (ok && found) begin
      m_ptr = (g + 1) % NS;
      b     = ids[g*IDSW +: IDSW];
      f     = b[IDSW-1:IW];
      if ($countones(f) == 1 && $clog2(f) < NM) begin
        m_full = 1;
        m_dst  = $clog2(f);
        m_id   = b[IW-1:0];
        m_resp = rs[g*2 +: 2];
        exp_q.push_back({1'(m_dst), m_id, m_resp});
      end else begin
        m_drops++;
      end
    end
  endtask

  function automatic logic [3:0] rand_field();
    case ($urandom_range(0, 5))
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0001;
      3:       return 4'b0010;
      4:       return 4'b0100;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [3:0] bad_field();
    case ($urandom_range(0, 4))
      0:       return 4'b0000;
      1:       return 4'b0011;
      2:       return 4'b0110;
      3:       return 4'b1000;
      default: return 4'b0100;
    endcase
  endfunction

  initial begin
    logic [NS*IDSW-1:0] ids;
    logic [NS*2-1:0]    rs;
    int                 cnt[NS];
    int                 d0;

    // reset
    rst          = 1'b0;
    bif.BVALID_S = '0;
    bif.BID_S    = '0;
    bif.BRESP_S  = '0;
    bif.BREADY_M = '0;
    model_reset();
    last_rs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bvalid_m", 32'(bif.BVALID_M), 32'd0);
    chk("reset_bready_s", 32'(bif.BREADY_S), 32'd0);
    chk("reset_bid_m",    32'(bif.BID_M),    32'd0);
    chk("reset_bresp_m",  32'(bif.BRESP_M),  32'd0);
    chk("reset_state",    32'(fsm_state),    32'(IDLE));
`ifdef WRESP_DROP_CNT_EN
    chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b1;

    // test 1: single response from slave 1 to master 1
    step(3'b010, {8'h00, 8'h2A, 8'h00}, {2'b00, OKAY, 2'b00}, 2'b11);
    chk("t1_bready_s", 32'(last_rs), 32'(3'b010));
    step(3'b000, '0, '0, 2'b11);
    chk("t1_bvalid_m", 32'(bif.BVALID_M), 32'(2'b10));
    chk("t1_bid_m1",   32'(bif.BID_M[IW +: IW]), 32'(4'hA));
    chk("t1_bresp_m1", 32'(bif.BRESP_M[3:2]), 32'(OKAY));
    step(3'b000, '0, '0, 2'b11);
    chk("t1_idle", 32'(fsm_state), 32'(IDLE));

    // test 2: all slaves streaming, one accept per cycle, fair rotation
    foreach (cnt[i]) cnt[i] = 0;
    for (int n = 0; n < 30; n++) begin
      ids = {4'b0001, 4'($urandom_range(0, 15)), 4'b0010, 4'($urandom_range(0, 15)),
             4'b0001, 4'($urandom_range(0, 15))};
      rs  = NS*2'($urandom);
      step(3'b111, ids, rs, 2'b11);
      for (int s = 0; s < NS; s++) if (last_rs[s]) cnt[s]++;
    end
    for (int s = 0; s < NS; s++) chk($sformatf("t2_grants_s%0d", s), 32'(cnt[s]), 32'd10);

    // test 3: master 0 back-pressure with S0 and S1 pending
    step(3'b000, '0, '0, 2'b11);
    step(3'b011, {8'h00, 8'h1C, 8'h13}, {2'b00, SLVERR, EXOKAY}, 2'b00);
    for (int n = 0; n < 5; n++) begin
      step(3'b011, {8'h00, 8'h1C, 8'h13}, {2'b00, SLVERR, EXOKAY}, 2'b00);
      chk("t3_stall_bready_s", 32'(last_rs), 32'd0);
      chk("t3_stall_bvalid_m", 32'(bif.BVALID_M), 32'(2'b01));
    end
    step(3'b011, {8'h00, 8'h1C, 8'h13}, {2'b00, SLVERR, EXOKAY}, 2'b01);
    chk("t3_release_accept", 32'(last_rs != 0), 32'd1);
    step(3'b000, '0, '0, 2'b01);
    step(3'b000, '0, '0, 2'b01);

    // test 4: unroutable master fields are sunk
    d0 = m_drops;
    step(3'b100, {8'h65, 8'h00, 8'h00}, '0, 2'b11);
    chk("t4_multihot_taken", 32'(last_rs), 32'(3'b100));
    step(3'b100, {8'h87, 8'h00, 8'h00}, '0, 2'b11);
    chk("t4_range_taken", 32'(last_rs), 32'(3'b100));
    step(3'b000, '0, '0, 2'b11);
    chk("t4_no_bvalid", 32'(bif.BVALID_M), 32'd0);
    chk("t4_model_drops", 32'(m_drops - d0), 32'd2);
`ifdef WRESP_DROP_CNT_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 32'(sat255(d0 + 2)));
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < NS; s++) ids[s*IDSW +: IDSW] = {rand_field(), 4'($urandom_range(0, 15))};
      rs = NS*2'($urandom);
      step(NS'($urandom_range(0, 7)), ids, rs, NM'($urandom_range(0, 3)));
    end
    step(3'b000, '0, '0, 2'b11);
    step(3'b000, '0, '0, 2'b11);

    // test 5: reset while holding a response for master 1
    step(3'b001, {8'h00, 8'h00, 8'h27}, '0, 2'b00);
    @(negedge clk);
    bif.BVALID_S = '0;
    rst          = 1'b0;
    #1;
    chk("t5_rst_bvalid_m", 32'(bif.BVALID_M), 32'd0);
    chk("t5_rst_bready_s", 32'(bif.BREADY_S), 32'd0);
    chk("t5_rst_state",    32'(fsm_state),    32'(IDLE));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(3'b111, {8'h15, 8'h15, 8'h15}, '0, 2'b11);
    chk("t5_first_grant", 32'(last_rs), 32'(3'b001));
    step(3'b000, '0, '0, 2'b11);

    // test 6: long run of invalid fields
    for (int n = 0; n < 300; n++) begin
      for (int s = 0; s < NS; s++) ids[s*IDSW +: IDSW] = {bad_field(), 4'($urandom_range(0, 15))};
      step(3'b111, ids, '0, 2'b11);
    end
    step(3'b000, '0, '0, 2'b11);
    chk("t6_model_drops", 32'(m_drops), 32'd300);
`ifdef WRESP_DROP_CNT_EN
    chk("t6_drop_cnt_sat", 32'(drop_cnt), 32'hFF);
`endif
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_wresp_rr_router.md
Name: axi_wresp_rr_router

Overview:
- Parametrised successor of the fixed 3-slave/1-master AXI write-response mux.
- Collects B-channel responses from NUM_S slaves and routes each to one of NUM_M masters; the destination comes from the one-hot master field in the upper ID bits.
- Arbitration is fair round-robin instead of fixed priority.
- A registered one-entry response slot decouples slave and master timing.
- Unroutable responses are sunk rather than stalling the bus.

Parameters:
NUM_S, 3, number of slave B channels (2..8)
NUM_M, 2, number of master B channels (1..MSEL_W)
ID_W, 4, master-side BID width
IDS_W, 8, slave-side BID width; bits [IDS_W-1:ID_W] are the one-hot master-select field, MSEL_W = IDS_W-ID_W

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is asynchronous and active-low
BID_S  in  NUM_S*IDS_W  slave BIDs, slave i at [i*IDS_W +: IDS_W]
BRESP_S  in  NUM_S*2  slave BRESPs
BVALID_S  in  NUM_S  slave BVALIDs
BREADY_S  out  NUM_S  slave BREADYs
BID_M  out  NUM_M*ID_W  master BIDs (lower ID_W bits of captured ID)
BRESP_M  out  NUM_M*2  master BRESPs
BVALID_M  out  NUM_M  master BVALIDs
BREADY_M  in  NUM_M  master BREADYs

Behaviour:
- Reset values:
  - BVALID_M=0, BREADY_S=0, BID_M=0, BRESP_M=0.
  - Slot empty.
  - RR pointer=0.
  - FSM=IDLE.
- FSM states:
  - IDLE (slot empty).
  - HOLD (slot full, waiting on the master).
- IDLE:
  - If any BVALID_S, grant the first requesting slave at or after the RR pointer (wrapping modulo NUM_S).
  - Assert BREADY_S[grant] combinationally in that cycle.
  - Capture its ID and RESP into the slot on the clock edge.
  - Set the pointer to (grant+1) mod NUM_S.
  - Next state is HOLD if the captured master field is one-hot and its index is < NUM_M; otherwise the response is dropped and the FSM stays in IDLE.
- HOLD:
  - BVALID_M[dst]=1 and all others 0; BID_M/BRESP_M[dst] driven from the slot. Non-selected master BID/BRESP outputs are 0.
  - BREADY_S is all 0 unless the master handshake completes this cycle.
- Back-to-back: in HOLD, when BVALID_M[dst]&BREADY_M[dst], the router may grant and accept a new slave response in the same cycle using the IDLE rules.
  - The slot is reloaded and the FSM stays in HOLD (or goes to IDLE if the new response is dropped or there is no request).
  - Peak throughput is one response per cycle.
- Latency: slave handshake at cycle N gives BVALID_M high at cycle N+1.
- Stability: slot contents and BVALID_M are held until the master handshake. A master may not see BVALID drop without a handshake.
- Only one BREADY_S bit is ever high. BREADY_S is never asserted while the slot is full without a concurrent master handshake.
- Pointer is updated only on an accepted grant, never on idle cycles.
- A slave that deasserts BVALID before being granted loses nothing; it is simply not granted.
- Reset mid-HOLD: the slot is discarded and BVALID_M drops asynchronously; an in-flight response is lost by design.

Optional Feature:
- Macro: WRESP_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (out, 8 bits).
  - Counts responses sunk for an invalid master field (zero, multi-hot, or index >= NUM_M).
  - Saturates at 255; reset value 0.
  - Increments in the same cycle the drop occurs.
- Undefined: the port and counter are absent; drop behaviour is otherwise identical.

Decomposition:
- Package axi_wresp_pkg:
  - state enum {IDLE, HOLD};
  - BRESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - function onehot_to_idx with a valid flag.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], advance.
  - Outputs: gnt[N] (one-hot), gnt_idx, any.
  - Holds its own pointer.
  - Reused later by the read-data router.

Test Plan:
1. Single slave 1 sends BID=8'h2A (field 4'b0010 -> master 1, ID 4'hA), BRESP=OKAY with BREADY_M=1. Expect BREADY_S=3'b010 at cycle 0; BVALID_M=2'b10, BID_M[1]=4'hA, BRESP_M[1]=0 at cycle 1; FSM back to IDLE.
2. All three slaves valid continuously, master always ready. Expect grant order S0,S1,S2,S0… with one accept per cycle and no starvation across 30 responses.
3. Master 0 holds BREADY_M=0 for 5 cycles while S0 and S1 are valid. Expect BVALID_M[0] and BID/BRESP stable for 5 cycles, BREADY_S=0 throughout, S1 accepted in the cycle BREADY_M rises.
4. S2 sends master field 4'b0110 (multi-hot), then 4'b1000 (index 3 >= NUM_M). Expect both accepted and dropped, no BVALID_M, drop_cnt=2 with WRESP_DROP_CNT_EN.
5. Assert rst low while in HOLD with BVALID_M[1]=1. Expect BVALID_M=0 immediately; after release, pointer=0 and the first grant goes to S0 when all slaves are valid.
6. Inject 300 invalid-field responses with WRESP_DROP_CNT_EN defined. Expect drop_cnt saturated at 8'hFF.
